determinant_sequencer: RTL
==========================

// Module: determinant_sequencer
// PURPOSE
//  Sequences one shared determinant ALU (2x2..5x5, 8-bit result) on behalf of the host command path.
//  - Accepts a matrix and size over a valid/ready request port, latches both and holds them stable on the ALU operand bus.
//  - Masks stale done after an operand change, then waits for ALU done (optional timeout) and returns result/overflow/error over a valid/ready response port.
//  - Sits between the instruction decoder and the determinant ALU.
// PARAMETERS
//  MATRIX_W        200  flattened 5x5x8-bit operand width
//  RESULT_W        8    determinant result width
//  SETTLE_CYCLES   2    cycles alu_done is ignored after operands are driven (1..15)
//  TIMEOUT_CYCLES  64   max WAIT cycles before a timeout error (only with DET_SEQ_TIMEOUT_EN)
// PORTS
//  clock          in   1         system clock, rising edge
//  reset_n        in   1         asynchronous reset, active low
//  req_valid      in   1         request present
//  req_ready      out  1         sequencer can accept (IDLE only)
//  req_matrix     in   MATRIX_W  flattened matrix, row-major
//  req_size       in   3         3'd2..3'd5 = 2x2..5x5; anything else is illegal
//  abort          in   1         sync abort: drop current op, return to IDLE, no response
//  alu_matrix     out  MATRIX_W  operand to ALU (registered)
//  alu_size       out  3         size to ALU (registered); 3'd0 when not in an operation
//  alu_number     in   RESULT_W  ALU determinant result
//  alu_done       in   1         ALU result valid
//  alu_overflow   in   1         ALU overflow flag
//  resp_valid     out  1         response present
//  resp_ready     in   1         consumer accepts response
//  resp_number    out  RESULT_W  captured determinant (0 on error)
//  resp_overflow  out  1         captured overflow (0 on error)
//  resp_error     out  2         2'b00 ok, 2'b01 illegal size, 2'b10 timeout
//  busy           out  1         high in any state except IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; alu_matrix=0, alu_size=0; resp_valid=0; resp_number=0;
//    resp_overflow=0; resp_error=0; counter=0. req_ready=1 on first edge after release.
//  States: IDLE -> SETTLE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly on illegal size.
//  IDLE: req_ready=1. On req_valid&req_ready with legal size: latch alu_matrix/alu_size, cnt=0, -> SETTLE.
//    Illegal size: alu_size stays 0; resp_error=01, number/overflow=0, -> RESP (resp_valid next cycle).
//  SETTLE: alu_done ignored; cnt++ each cycle; when cnt==SETTLE_CYCLES-1 -> WAIT, cnt=0.
//  WAIT: first cycle with alu_done=1: capture alu_number, alu_overflow, error=00, -> RESP.
//  RESP: resp_valid=1, outputs stable until resp_valid&resp_ready; then -> IDLE, alu_size=0, alu_matrix held.
//  alu_size is forced to 0 in IDLE so ALU done deasserts between ops; no back-to-back accept in RESP.
//  Minimum latency, legal request: accept edge -> resp_valid high after SETTLE_CYCLES+1 edges when alu_done already high.
//  abort: highest priority in SETTLE/WAIT/RESP; next state IDLE; resp_valid=0; alu_size=0. Ignored in IDLE.
//  Simultaneous abort and alu_done in WAIT: abort wins, nothing captured.
//  Simultaneous abort and resp_ready in RESP: the response counts as not delivered.
//  req_valid in a non-IDLE state is not accepted (req_ready=0) and is not buffered.
//  Counter saturates; widths are not sign-extended. Result passes through unmodified (8-bit two's complement from ALU).
// CONFIGURATION
//  DET_SEQ_TIMEOUT_EN defined: cnt also counts in WAIT.
//    At cnt==TIMEOUT_CYCLES-1 without alu_done: error=10, number=0, overflow=0, -> RESP.
//    alu_done on the same cycle wins over the timeout.
//  DET_SEQ_TIMEOUT_EN undefined: WAIT holds indefinitely until alu_done or abort; resp_error never 10.
// TESTING
//  T1 2x2 [[3,1],[2,4]], size=2, alu model done after 1 cycle -> one resp: number=8'd10, overflow=0, error=00.
//  T2 req_size=3'd7 -> no alu_size change (stays 0), resp_valid next cycle: error=01, number=0.
//  T3 resp_ready low 10 cycles in RESP -> resp_* stable, req_ready=0 throughout; handshake -> IDLE next edge.
//  T4 alu_done stuck high from cycle 0 -> done ignored for SETTLE_CYCLES=2; capture on first WAIT cycle.
//  T5 abort asserted in WAIT together with alu_done -> IDLE, no resp_valid, alu_size=0; next request completes normally.
//  T6 TIMEOUT_EN, alu_done never high -> resp error=10 after 2+64 cycles; reset_n low mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/determinant_sequencer.sv
// Sequencer for one shared determinant ALU: request latch, settle masking, done wait, response hold.
// Optional WAIT timeout enabled by defining DET_SEQ_TIMEOUT_EN.
module determinant_sequencer #(
  parameter int MATRIX_W       = 200,
  parameter int RESULT_W       = 8,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [MATRIX_W-1:0] req_matrix,
  input  logic [2:0]          req_size,
  input  logic                abort,
  output logic [MATRIX_W-1:0] alu_matrix,
  output logic [2:0]          alu_size,
  input  logic [RESULT_W-1:0] alu_number,
  input  logic                alu_done,
  input  logic                alu_overflow,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [RESULT_W-1:0] resp_number,
  output logic                resp_overflow,
  output logic [1:0]          resp_error,
  output logic                busy
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + TIMEOUT_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_SIZE = 2'b01;
`ifdef DET_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc_s;
  logic [MATRIX_W-1:0]   alu_matrix_q, alu_matrix_d;
  logic [2:0]            alu_size_q, alu_size_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [RESULT_W-1:0]   resp_number_q, resp_number_d;
  logic                  resp_overflow_q, resp_overflow_d;
  logic [1:0]            resp_error_q, resp_error_d;
  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;

  function automatic logic size_legal(input logic [2:0] s);
    return (s >= 3'd2) && (s <= 3'd5);
  endfunction

  assign cnt_inc_s = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    alu_matrix_d    = alu_matrix_q;
    alu_size_d      = alu_size_q;
    resp_valid_d    = resp_valid_q;
    resp_number_d   = resp_number_q;
    resp_overflow_d = resp_overflow_q;
    resp_error_d    = resp_error_q;
    case (state_q)
      ST_IDLE: begin
        alu_size_d   = 3'd0;
        resp_valid_d = 1'b0;
        if (req_valid && req_ready_q) begin
          if (size_legal(req_size)) begin
            alu_matrix_d = req_matrix;
            alu_size_d   = req_size;
            cnt_d        = '0;
            state_d      = ST_SETTLE;
          end else begin
            resp_error_d    = ERR_SIZE;
            resp_number_d   = '0;
            resp_overflow_d = 1'b0;
            resp_valid_d    = 1'b1;
            state_d         = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        // alu_done may still reflect the previous operand set here.
        if (abort) begin
          state_d      = ST_IDLE;
          alu_size_d   = 3'd0;
          resp_valid_d = 1'b0;
          cnt_d        = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d      = ST_IDLE;
          alu_size_d   = 3'd0;
          resp_valid_d = 1'b0;
          cnt_d        = '0;
        end else if (alu_done) begin
          resp_number_d   = alu_number;
          resp_overflow_d = alu_overflow;
          resp_error_d    = ERR_OK;
          resp_valid_d    = 1'b1;
          state_d         = ST_RESP;
        end else begin
`ifdef DET_SEQ_TIMEOUT_EN
          if (cnt_q == TIMEOUT_LAST) begin
            resp_number_d   = '0;
            resp_overflow_d = 1'b0;
            resp_error_d    = ERR_TIMEOUT;
            resp_valid_d    = 1'b1;
            state_d         = ST_RESP;
          end else begin
            cnt_d = cnt_inc_s;
          end
`else
          state_d = ST_WAIT;
`endif
        end
      end
      ST_RESP: begin
        // Abort beats the handshake: the response is treated as undelivered.
        if (abort || resp_ready) begin
          state_d      = ST_IDLE;
          alu_size_d   = 3'd0;
          resp_valid_d = 1'b0;
          cnt_d        = '0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        alu_size_d   = 3'd0;
        resp_valid_d = 1'b0;
        cnt_d        = '0;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered-output flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      alu_matrix_q    <= '0;
      alu_size_q      <= 3'd0;
      resp_valid_q    <= 1'b0;
      resp_number_q   <= '0;
      resp_overflow_q <= 1'b0;
      resp_error_q    <= 2'b00;
      req_ready_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      alu_matrix_q    <= alu_matrix_d;
      alu_size_q      <= alu_size_d;
      resp_valid_q    <= resp_valid_d;
      resp_number_q   <= resp_number_d;
      resp_overflow_q <= resp_overflow_d;
      resp_error_q    <= resp_error_d;
      req_ready_q     <= req_ready_d;
      busy_q          <= busy_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign alu_matrix    = alu_matrix_q;
  assign alu_size      = alu_size_q;
  assign resp_valid    = resp_valid_q;
  assign resp_number   = resp_number_q;
  assign resp_overflow = resp_overflow_q;
  assign resp_error    = resp_error_q;

endmodule
